axi_trx_slave_bridge: RTL and testbench

- AXI4 slave front-end that turns host AXI write/read bursts into the per-beat trx_t request stream consumed by the AXI-DMA bridge.
- Returns the bridge's read data to the host on the R channel through an in-order buffer of RD_DATA_DEPTH entries.
- Sits between the host interconnect and the DMA/PIM request path.
- Uses the axi_lib package for widths and the trx_t type.

---
 rtl/axi_trx_slave_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_trx_slave_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_trx_slave_bridge.sv
// axi_lib: shared widths and the per-beat request type consumed by the DMA bridge.
//
// axi_trx_slave_bridge: AXI4 slave front-end. It accepts one write or read burst
// at a time and expands it into per-beat trx_t requests. Read data comes back
// from the bridge in request order and is returned on R through a
// RD_DATA_DEPTH-entry in-order buffer.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   S_AXI_AW*/W*/B*            : write address / data / response channels
//   S_AXI_AR*/R*               : read address / data channels
//   trx_o, trx_valid_o/ready_i : one-entry request register toward the bridge
//   rd_data_i, rd_valid_i      : in-order read returns, no backpressure
package axi_lib;
  localparam int TRX_ADDR_W = 32;
  localparam int TRX_DATA_W = 256;
  localparam int TRX_MASK_W = 16;

  typedef struct packed {
    logic                  is_rd;
    logic [TRX_ADDR_W-1:0] addr;
    logic [TRX_MASK_W-1:0] mask;
    logic [TRX_DATA_W-1:0] data;
  } trx_t;
endpackage

module axi_trx_slave_bridge #(
  parameter int AXI_ID_WIDTH   = 2,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_MASK_WIDTH = 16,
  parameter int RD_DATA_DEPTH  = 64
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output axi_lib::trx_t               trx_o,
  output logic                        trx_valid_o,
  input  logic                        trx_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   rd_data_i,
  input  logic                        rd_valid_i
);

  localparam int OFFS = $clog2(AXI_DATA_WIDTH/8);
  localparam int CW   = $clog2(RD_DATA_DEPTH+1);
  localparam int PW   = $clog2(RD_DATA_DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RD_DATA_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(RD_DATA_DEPTH-1);

  typedef enum logic [1:0] {IDLE, WR_BURST, WR_RESP, RD_BURST} state_e;

  state_e                    state_q, state_d;
  logic                      prio_q;      // 1: read wins a simultaneous AW/AR
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] base_q;
  logic [7:0]                len_q;
  logic [7:0]                wbeat_q;
  logic [8:0]                issued_q;    // read trx issued; reaches len+1
  logic [7:0]                rbeat_q;
  logic [CW-1:0]             outst_q, cnt_q;
  logic [PW-1:0]             wptr_q, rptr_q;
  axi_lib::trx_t             trx_q;
  logic                      trx_vld_q;
  logic                      bvalid_q;
  logic [AXI_DATA_WIDTH-1:0] mem [RD_DATA_DEPTH];

  logic aw_rdy, ar_rdy, aw_hs, ar_hs, w_hs, b_hs;
  logic reg_free, wready, rd_issue, room, push, pop, rvalid, rlast, ret;
  logic [CW:0] inflight;
  logic [AXI_MASK_WIDTH-1:0] wmask;
  logic unused_wlast;

  // Burst length comes from the latched AxLEN, not from WLAST.
  assign unused_wlast = S_AXI_WLAST;

  for (genvar g = 0; g < AXI_MASK_WIDTH; g++) begin : g_mask
    assign wmask[g] = S_AXI_WSTRB[2*g] & S_AXI_WSTRB[2*g+1];
  end

  // INCR at full width; beat 0 keeps the unaligned offset, later beats are
  // line-aligned. Wraps modulo 2^ADDR_WIDTH.
  function automatic logic [AXI_ADDR_WIDTH-1:0] beat_addr(
    input logic [AXI_ADDR_WIDTH-1:0] base, input logic [7:0] k);
    logic [AXI_ADDR_WIDTH-OFFS-1:0] line;
    line = base[AXI_ADDR_WIDTH-1:OFFS] + (AXI_ADDR_WIDTH-OFFS)'(k);
    return (k == 8'd0) ? base : {line, {OFFS{1'b0}}};
  endfunction

  assign aw_hs    = S_AXI_AWVALID & aw_rdy;
  assign ar_hs    = S_AXI_ARVALID & ar_rdy;
  assign reg_free = !trx_vld_q | trx_ready_i;
  assign wready   = (state_q == WR_BURST) & reg_free;
  assign w_hs     = S_AXI_WVALID & wready;
  assign b_hs     = bvalid_q & S_AXI_BREADY;

  // Credit: every issued read owns a buffer slot until it is popped on R.
  assign inflight = {1'b0, outst_q} + {1'b0, cnt_q};
  assign room     = inflight < {1'b0, DEPTH_C};
  assign rd_issue = (state_q == RD_BURST) & (issued_q <= {1'b0, len_q}) & reg_free & room;
  assign push     = rd_valid_i & (cnt_q != DEPTH_C);
  assign rvalid   = (cnt_q != '0);
  assign pop      = rvalid & S_AXI_RREADY;
  assign rlast    = (rbeat_q == len_q);
  assign ret      = rd_valid_i & (outst_q != '0);

  always_comb begin
    state_d = state_q;
    aw_rdy  = 1'b0;
    ar_rdy  = 1'b0;
    case (state_q)
      IDLE: begin
        aw_rdy = S_AXI_ARESETN & (!S_AXI_ARVALID | !prio_q);
        ar_rdy = S_AXI_ARESETN & (!S_AXI_AWVALID |  prio_q);
        if (S_AXI_AWVALID && aw_rdy)      state_d = WR_BURST;
        else if (S_AXI_ARVALID && ar_rdy) state_d = RD_BURST;
      end
      WR_BURST: if (w_hs && wbeat_q == len_q) state_d = WR_RESP;
      WR_RESP:  if (b_hs)                     state_d = IDLE;
      RD_BURST: if (pop && rlast)             state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      id_q      <= '0;
      base_q    <= '0;
      len_q     <= '0;
      wbeat_q   <= '0;
      issued_q  <= '0;
      rbeat_q   <= '0;
      outst_q   <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      trx_q     <= '0;
      trx_vld_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (aw_hs || ar_hs) begin
        id_q     <= aw_hs ? S_AXI_AWID   : S_AXI_ARID;
        base_q   <= aw_hs ? S_AXI_AWADDR : S_AXI_ARADDR;
        len_q    <= aw_hs ? S_AXI_AWLEN  : S_AXI_ARLEN;
        wbeat_q  <= '0;
        issued_q <= '0;
        rbeat_q  <= '0;
        if (S_AXI_AWVALID && S_AXI_ARVALID) prio_q <= !prio_q;
      end

      if (w_hs) begin
        trx_q     <= '{is_rd: 1'b0, addr: beat_addr(base_q, wbeat_q),
                       mask: wmask, data: S_AXI_WDATA};
        trx_vld_q <= 1'b1;
        wbeat_q   <= wbeat_q + 8'd1;
      end else if (rd_issue) begin
        trx_q     <= '{is_rd: 1'b1, addr: beat_addr(base_q, issued_q[7:0]),
                       mask: '1, data: '0};
        trx_vld_q <= 1'b1;
        issued_q  <= issued_q + 9'd1;
      end else if (trx_ready_i) begin
        trx_vld_q <= 1'b0;
      end

      // In WR_RESP the register can only hold the final write beat.
      if (state_q == WR_RESP && trx_vld_q && trx_ready_i) bvalid_q <= 1'b1;
      else if (b_hs)                                      bvalid_q <= 1'b0;

      case ({rd_issue, ret})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: ;
      endcase

      if (push) wptr_q <= (wptr_q == LAST_PTR) ? '0 : wptr_q + PW'(1);
      if (pop) begin
        rptr_q  <= (rptr_q == LAST_PTR) ? '0 : rptr_q + PW'(1);
        rbeat_q <= rbeat_q + 8'd1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wptr_q] <= rd_data_i;
  end

  a_no_overflow: assert property (@(posedge S_AXI_ACLK) disable iff (!S_AXI_ARESETN)
                                  !(rd_valid_i && cnt_q == DEPTH_C));

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BID     = id_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RID     = id_q;
  assign S_AXI_RDATA   = rvalid ? mem[rptr_q] : '0;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RLAST   = rvalid & rlast;
  assign S_AXI_RVALID  = rvalid;
  assign trx_o         = trx_q;
  assign trx_valid_o   = trx_vld_q;

endmodule

// File: tb/tb_axi_trx_slave_bridge.sv
// Randomized bench for axi_trx_slave_bridge: an AXI master driven from tasks,
// a downstream DMA model returning read data in order, and a burst-level
// reference model (beat address / mask rules, in-order read scoreboard).
module tb_axi_trx_slave_bridge;
  import axi_lib::*;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [1:0]   awid = '0, arid = '0, bid, rid, bresp, rresp;
  logic [31:0]  awaddr = '0, araddr = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic         awvalid = 1'b0, awready, arvalid = 1'b0, arready;
  logic [255:0] wdata = '0, rdata, rd_data_i = '0;
  logic [31:0]  wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0, wready;
  logic         bvalid, bready = 1'b0, rlast, rvalid, rready = 1'b0;
  trx_t         trx_o;
  logic         trx_valid_o, trx_ready_i = 1'b0, rd_valid_i = 1'b0;

  always #5 clk = ~clk;

  axi_trx_slave_bridge u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .trx_o(trx_o), .trx_valid_o(trx_valid_o), .trx_ready_i(trx_ready_i),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] ref_addr(input logic [31:0] base, input int k);
    logic [31:0] a;
    a = (base & 32'hFFFF_FFE0) + 32'(k * 32);
    return (k == 0) ? base : a;
  endfunction

  function automatic logic [15:0] strb2mask(input logic [31:0] s);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = s[2*i] & s[2*i+1];
    return m;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- downstream DMA model ----------------
  typedef struct { int due; logic [255:0] d; } rd_ent_t;
  rd_ent_t      pend[$];
  logic [255:0] exp_r[$];
  trx_t         got[$];
  int           cyc = 0, rd_lat = 3, last_due = 0, stall_left = 0;
  logic [31:0]  stall_addr = 32'hFFFF_FFFF;
  bit           rdy_rand = 0, rr_rand = 0, gaps = 0;
  logic [255:0] wd [256];
  logic [31:0]  ws [256];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin : ds_drv
    rd_ent_t e;
    if (!rst_n) begin
      trx_ready_i = 1'b0;
      rd_valid_i  = 1'b0;
    end else begin
      if (trx_valid_o && !trx_o.is_rd && trx_o.addr == stall_addr && stall_left > 0) begin
        trx_ready_i = 1'b0;
        stall_left--;
      end else begin
        trx_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        e = pend.pop_front();
        rd_valid_i = 1'b1;
        rd_data_i  = e.d;
      end else begin
        rd_valid_i = 1'b0;
      end
    end
  end

  // Observes handshakes that will complete at the next rising edge.
  always @(negedge clk) begin : mon
    rd_ent_t e;
    int      due;
    #1;
    if (rst_n) begin
      if (trx_valid_o && trx_ready_i) begin
        got.push_back(trx_o);
        if (trx_o.is_rd) begin
          due = cyc + rd_lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          e.due = due;
          e.d   = rnd256();
          pend.push_back(e);
          exp_r.push_back(e.d);
        end
      end
      if (trx_valid_o && !trx_ready_i) chk("wready_full", wready, 1'b0);
    end
  end

  // ---------------- master tasks (start and end on a falling edge) ----------------
  task automatic aw_send(input logic [1:0] id, input logic [31:0] a, input int len);
    int t = 0;
    awid = id; awaddr = a; awlen = 8'(len); awvalid = 1'b1;
    #1;
    while (!awready && t < 200) begin @(negedge clk); #1; t++; end
    chk("aw_timeout", t < 200, 1'b1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [1:0] id, input logic [31:0] a, input int len);
    int t = 0;
    arid = id; araddr = a; arlen = 8'(len); arvalid = 1'b1;
    #1;
    while (!arready && t < 200) begin @(negedge clk); #1; t++; end
    chk("ar_timeout", t < 200, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic contest(input bit exp_wr, input logic [1:0] wid, input logic [31:0] wa,
                         input int wl, input logic [1:0] rid_, input logic [31:0] ra, input int rl);
    awid = wid; awaddr = wa; awlen = 8'(wl); awvalid = 1'b1;
    arid = rid_; araddr = ra; arlen = 8'(rl); arvalid = 1'b1;
    #1;
    chk("arb_awready", awready, exp_wr);
    chk("arb_arready", arready, !exp_wr);
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic wr_body(input logic [1:0] id, input logic [31:0] base, input int len);
    int t;
    bit ok = 1;
    for (int k = 0; k <= len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wvalid = 1'b1; wdata = wd[k]; wstrb = ws[k]; wlast = (k == len);
      #1;
      t = 0;
      while (!wready && t < 200) begin @(negedge clk); #1; t++; end
      if (t >= 200) ok = 0;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("w_timeout", ok, 1'b1);
    t = 0;
    #1;
    while (!bvalid && t < 500) begin @(negedge clk); #1; t++; end
    chk("b_timeout", t < 500, 1'b1);
    chk("b_after_trx", got.size(), len + 1);
    chk("bid", bid, id);
    chk("bresp", bresp, 2'b00);
    @(negedge clk);
    bready = 1'b1;
    #1;
    chk("b_hold", bvalid, 1'b1);
    @(negedge clk);
    bready = 1'b0;
    for (int k = 0; k <= len && k < got.size(); k++) begin
      chk("wr_is_rd", got[k].is_rd, 1'b0);
      chk("wr_addr", got[k].addr, ref_addr(base, k));
      chk("wr_mask", got[k].mask, strb2mask(ws[k]));
      chk("wr_data", got[k].data, wd[k]);
    end
  endtask

  task automatic rd_body(input logic [1:0] id, input logic [31:0] base, input int len,
                         input int hold, input int abort_at);
    int beat = 0, t = 0, nrd;
    logic [255:0] e;
    while (beat <= len && beat != abort_at && t < 5000) begin
      rready = (t < hold) ? 1'b0 : (rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (hold > 0 && t == hold) begin
        nrd = 0;
        foreach (got[i]) if (got[i].is_rd) nrd++;
        chk("rd_credit", nrd, (len + 1 > 64) ? 64 : len + 1);
      end
      #1;
      if (rvalid && rready) begin
        e = (exp_r.size() > 0) ? exp_r.pop_front() : '0;
        chk("rdata", rdata, e);
        chk("rid", rid, id);
        chk("rresp", rresp, 2'b00);
        chk("rlast", rlast, beat == len);
        beat++;
      end
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    chk("r_timeout", (beat > len) || (beat == abort_at), 1'b1);
    if (abort_at < 0) begin
      chk("rd_cnt", got.size(), len + 1);
      for (int k = 0; k <= len && k < got.size(); k++) begin
        chk("rd_is_rd", got[k].is_rd, 1'b1);
        chk("rd_addr", got[k].addr, ref_addr(base, k));
        chk("rd_mask", got[k].mask, 16'hFFFF);
        chk("rd_data0", got[k].data, '0);
      end
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_awready"}, awready, 1'b0);
    chk({pfx, "_arready"}, arready, 1'b0);
    chk({pfx, "_wready"}, wready, 1'b0);
    chk({pfx, "_bvalid"}, bvalid, 1'b0);
    chk({pfx, "_rvalid"}, rvalid, 1'b0);
    chk({pfx, "_rlast"}, rlast, 1'b0);
    chk({pfx, "_trx_valid"}, trx_valid_o, 1'b0);
    chk({pfx, "_trx_nz"}, |trx_o, 1'b0);
    chk({pfx, "_resp"}, {bresp, rresp}, 4'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  id;
    logic [31:0] base;
    int          len;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous AW/AR: write first (single beat at 0x1000), then read (wrap).
    got.delete();
    wd[0] = rnd256(); ws[0] = 32'hFFFF_FFFF;
    contest(1'b1, 2'd1, 32'h1000, 0, 2'd2, 32'hFFFF_FFE0, 1);
    wr_body(2'd1, 32'h1000, 0);
    got.delete();
    contest(1'b0, 2'd3, 32'h3000, 0, 2'd2, 32'hFFFF_FFE0, 1);
    rd_body(2'd2, 32'hFFFF_FFE0, 1, 0, -1);
    if (got.size() > 1) chk("wrap_addr", got[1].addr, 32'h0);

    // 4-beat write, downstream stalls 3 cycles on beat 2.
    got.delete();
    for (int k = 0; k < 4; k++) begin wd[k] = rnd256(); ws[k] = 32'h0000_000F; end
    stall_addr = 32'h2040; stall_left = 3;
    aw_send(2'd0, 32'h2000, 3);
    wr_body(2'd0, 32'h2000, 3);
    stall_addr = 32'hFFFF_FFFF;

    // 16-beat read, fixed return latency.
    rd_lat = 5;
    got.delete();
    ar_send(2'd3, 32'h8000_0000, 15);
    rd_body(2'd3, 32'h8000_0000, 15, 0, -1);

    // 80-beat read with R held off: issue must stop at the buffer depth.
    rd_lat = 2;
    got.delete();
    ar_send(2'd1, 32'h0001_0000, 79);
    rd_body(2'd1, 32'h0001_0000, 79, 200, -1);

    // Randomized bursts.
    rdy_rand = 1; rr_rand = 1; gaps = 1;
    for (int i = 0; i < 24; i++) begin
      rd_lat = $urandom_range(1, 8);
      id   = 2'($urandom_range(0, 3));
      base = $urandom;
      len  = $urandom_range(0, 20);
      got.delete();
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= len; k++) begin wd[k] = rnd256(); ws[k] = $urandom; end
        aw_send(id, base, len);
        wr_body(id, base, len);
      end else begin
        ar_send(id, base, len);
        rd_body(id, base, len, 0, -1);
      end
    end
    rdy_rand = 0; rr_rand = 0; gaps = 0;

    // Reset in the middle of an 8-beat read.
    rd_lat = 2;
    got.delete();
    ar_send(2'd1, 32'h4000, 7);
    rd_body(2'd1, 32'h4000, 7, 0, 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    pend.delete(); exp_r.delete(); got.delete(); last_due = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);
    @(negedge clk);

    // Arbitration priority restarts at write after reset.
    got.delete();
    for (int k = 0; k < 3; k++) begin wd[k] = rnd256(); ws[k] = $urandom; end
    contest(1'b1, 2'd2, 32'h5004, 2, 2'd1, 32'h6000, 0);
    wr_body(2'd2, 32'h5004, 2);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
